writeback_unit: RTL and testbench

//  Write-back stage that drives the register file write port: RegWrite, WriteAddr and Writedata.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/wb_queue.sv | 80 ++++++++
 rtl/writeback_unit.sv | 130 +++++++++++++
 tb/tb_writeback_unit.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared widths, register constants and the write-back entry type.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;

    localparam logic [ADDR_W-1:0] REG_ZERO  = 4'h0;
    localparam logic [ADDR_W-1:0] OP_TYPE_A = 4'hF;

    typedef struct packed {
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

`default_nettype wire

// File: rtl/wb_queue.sv
// ============================================================================
//  Module      : wb_queue
//  Description : In-order FIFO of write-back entries; exposes every slot in age order.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  wb_entry_t                  push_entry,
    input  logic                       pop,
    output logic                       full,
    output logic                       empty,
    output wb_entry_t                  head,
    output wb_entry_t [DEPTH-1:0]      entries,
    output logic [DEPTH-1:0]           valid,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t          r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign full      = (r_count == CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;
    assign head      = r_mem[r_rd_ptr];
    assign count     = r_count;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_entry;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Slot i is the i-th oldest entry, so higher indices are younger.
    for (genvar i = 0; i < DEPTH; i++) begin : g_age
        logic [PTR_W-1:0] w_idx;
        assign w_idx      = r_rd_ptr + PTR_W'(i);
        assign entries[i] = r_mem[w_idx];
        assign valid[i]   = (CNT_W'(i) < r_count);
    end

endmodule

`default_nettype wire

// File: rtl/writeback_unit.sv
// ============================================================================
//  Module      : writeback_unit
//  Description : Queues execute results, retires one per cycle to the register file,
//                and reports pending-write hazards with forwarding data.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module writeback_unit
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              res_valid,
    output logic              res_ready,
    input  logic [ADDR_W-1:0] res_dest,
    input  logic [DATA_W-1:0] res_data,
    input  logic              wb_stall,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] WriteAddr,
    output logic [DATA_W-1:0] Writedata,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic              hazard1,
    output logic              hazard2,
    output logic [DATA_W-1:0] fwd_data1,
    output logic [DATA_W-1:0] fwd_data2,
    output logic [ADDR_W-1:0] pending
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    wb_entry_t             w_head;
    wb_entry_t [DEPTH-1:0] w_entries;
    logic [DEPTH-1:0]      w_valid;
    logic [CNT_W-1:0]      w_count;
    wb_entry_t             w_push_entry;

    logic                  r_reg_write;
    logic [ADDR_W-1:0]     r_write_addr;
    logic [DATA_W-1:0]     r_write_data;

    assign res_ready         = ~reset & ~w_full;
    assign w_push            = res_valid & res_ready;
    assign w_pop             = ~w_empty & ~wb_stall;
    assign w_push_entry.dest = res_dest;
    assign w_push_entry.data = res_data;
    assign pending           = ADDR_W'(w_count);

    wb_queue #(
        .DEPTH      (DEPTH)
    ) u_queue (
        .clk        (clk),
        .reset      (reset),
        .push       (w_push),
        .push_entry (w_push_entry),
        .pop        (w_pop),
        .full       (w_full),
        .empty      (w_empty),
        .head       (w_head),
        .entries    (w_entries),
        .valid      (w_valid),
        .count      (w_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_reg_write  <= 1'b0;
            r_write_addr <= '0;
            r_write_data <= '0;
        end else if (w_pop) begin
            r_reg_write  <= (w_head.dest != REG_ZERO);
            r_write_addr <= w_head.dest;
            r_write_data <= w_head.data;
        end else begin
            r_reg_write  <= 1'b0;
        end
    end

    assign RegWrite  = r_reg_write;
    assign WriteAddr = r_write_addr;
    assign Writedata = r_write_data;

    // Scan oldest to youngest so the last hit is the youngest producer;
    // the output stage is older than anything still queued.
    function automatic logic [DATA_W:0] find_youngest(
        input logic [ADDR_W-1:0]     addr,
        input wb_entry_t [DEPTH-1:0] ents,
        input logic [DEPTH-1:0]      vld,
        input logic                  out_we,
        input logic [ADDR_W-1:0]     out_addr,
        input logic [DATA_W-1:0]     out_data
    );
        logic [DATA_W:0] result;
        result = '0;
        if (addr != REG_ZERO) begin
            if (out_we && (out_addr == addr)) begin
                result = {1'b1, out_data};
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (vld[i] && (ents[i].dest == addr)) begin
                    result = {1'b1, ents[i].data};
                end
            end
        end
        return result;
    endfunction

    logic [DATA_W:0] w_hit1;
    logic [DATA_W:0] w_hit2;

    always_comb begin
        w_hit1 = find_youngest(rd_addr1, w_entries, w_valid, r_reg_write, r_write_addr, r_write_data);
        w_hit2 = find_youngest(rd_addr2, w_entries, w_valid, r_reg_write, r_write_addr, r_write_data);
    end

    assign hazard1   = w_hit1[DATA_W];
    assign fwd_data1 = w_hit1[DATA_W-1:0];
    assign hazard2   = w_hit2[DATA_W];
    assign fwd_data2 = w_hit2[DATA_W-1:0];

endmodule

`default_nettype wire

// File: tb/tb_writeback_unit.sv
// ============================================================================
//  Module      : tb_writeback_unit
//  Description : Directed and random stimulus against a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_writeback_unit;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        res_valid = 1'b0;
    logic        res_ready;
    logic [3:0]  res_dest = '0;
    logic [15:0] res_data = '0;
    logic        wb_stall = 1'b0;
    logic        RegWrite;
    logic [3:0]  WriteAddr;
    logic [15:0] Writedata;
    logic [3:0]  rd_addr1 = '0;
    logic [3:0]  rd_addr2 = '0;
    logic        hazard1;
    logic        hazard2;
    logic [15:0] fwd_data1;
    logic [15:0] fwd_data2;
    logic [3:0]  pending;

    writeback_unit #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_dest  (res_dest),
        .res_data  (res_data),
        .wb_stall  (wb_stall),
        .RegWrite  (RegWrite),
        .WriteAddr (WriteAddr),
        .Writedata (Writedata),
        .rd_addr1  (rd_addr1),
        .rd_addr2  (rd_addr2),
        .hazard1   (hazard1),
        .hazard2   (hazard2),
        .fwd_data1 (fwd_data1),
        .fwd_data2 (fwd_data2),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  d;
        logic [15:0] v;
    } ent_t;

    ent_t        mq[$];
    bit          m_rw;
    logic [3:0]  m_wa;
    logic [15:0] m_wd;
    bit          m_known;
    bit          m_acc;

    int vectors;
    int miscompares;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Youngest pending write to a register: newest queued first, then the output stage.
    task automatic ref_fwd(input logic [3:0] a, output bit h, output logic [15:0] d);
        h = 1'b0;
        d = '0;
        if (a != 4'd0) begin
            for (int i = mq.size() - 1; i >= 0; i--) begin
                if (mq[i].d == a) begin
                    h = 1'b1;
                    d = mq[i].v;
                    break;
                end
            end
            if (!h && m_rw && m_wa == a) begin
                h = 1'b1;
                d = m_wd;
            end
        end
    endtask

    // One clock: drive at negedge, check just after, then advance the model past the next posedge.
    task automatic cyc(input bit rst_i, input bit v, input logic [3:0] d, input logic [15:0] dat,
                       input bit st, input logic [3:0] a1, input logic [3:0] a2);
        bit          h1, h2, acc, pop;
        logic [15:0] f1, f2;
        ent_t        e;
        @(negedge clk);
        reset = rst_i; res_valid = v; res_dest = d; res_data = dat;
        wb_stall = st; rd_addr1 = a1; rd_addr2 = a2;
        #1;
        chk("res_ready", res_ready, (!rst_i && mq.size() < DEPTH && m_known) ? 1 : 0);
        if (m_known) begin
            ref_fwd(a1, h1, f1);
            ref_fwd(a2, h2, f2);
            chk("pending", pending, mq.size());
            chk("RegWrite", RegWrite, m_rw);
            chk("WriteAddr", WriteAddr, m_wa);
            chk("Writedata", Writedata, m_wd);
            chk("hazard1", hazard1, h1);
            chk("fwd_data1", fwd_data1, f1);
            chk("hazard2", hazard2, h2);
            chk("fwd_data2", fwd_data2, f2);
        end
        if (rst_i) begin
            mq.delete();
            m_rw = 0; m_wa = '0; m_wd = '0; m_known = 1; m_acc = 0;
        end else begin
            acc = v && (mq.size() < DEPTH);
            pop = (mq.size() != 0) && !st;
            if (pop) begin
                e = mq.pop_front();
                m_rw = (e.d != 4'd0);
                m_wa = e.d;
                m_wd = e.v;
            end else begin
                m_rw = 0;
            end
            if (acc) begin
                e.d = d;
                e.v = dat;
                mq.push_back(e);
            end
            m_acc = acc;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 4'd0, 16'd0, 0, 4'd0, 4'd0);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        m_known = 0;

        // Reset for two cycles, then quiet outputs and an open input.
        cyc(1, 0, 4'd0, 16'd0, 0, 4'd0, 4'd0);
        cyc(1, 0, 4'd0, 16'd0, 0, 4'd0, 4'd0);
        cyc(0, 0, 4'd0, 16'd0, 0, 4'd0, 4'd0);
        chk("rst_ready", res_ready, 1);
        chk("rst_pending", pending, 0);

        // Single result: one write pulse one edge after it is queued.
        cyc(0, 1, 4'd3, 16'hFF0F, 0, 4'd3, 4'd0);
        cyc(0, 0, 4'd0, 16'd0, 0, 4'd3, 4'd0);
        chk("single_hold", RegWrite, 0);
        cyc(0, 0, 4'd0, 16'd0, 0, 4'd3, 4'd0);
        chk("single_we", RegWrite, 1);
        chk("single_addr", WriteAddr, 4'd3);
        chk("single_data", Writedata, 16'hFF0F);
        chk("single_haz_out", hazard1, 1);
        cyc(0, 0, 4'd0, 16'd0, 0, 4'd0, 4'd0);
        chk("single_we_end", RegWrite, 0);
        chk("single_pending", pending, 0);

        // Fill while stalled, fifth result waits for space.
        for (int i = 0; i < 4; i++) cyc(0, 1, 4'(i + 1), 16'(16'h1100 + i), 1, 4'd2, 4'd4);
        cyc(0, 1, 4'd7, 16'h7777, 1, 4'd2, 4'd7);
        chk("full_ready", res_ready, 0);
        chk("full_pending", pending, 4);
        begin
            bit got = 0;
            for (int i = 0; i < 5 && !got; i++) begin
                cyc(0, 1, 4'd7, 16'h7777, 0, 4'd1, 4'd7);
                got = m_acc;
            end
            chk("fifth_accepted", got, 1);
        end
        idle(7);

        // Duplicate destination: youngest value forwards.
        cyc(0, 1, 4'd5, 16'h0040, 1, 4'd5, 4'd6);
        cyc(0, 1, 4'd5, 16'h1234, 1, 4'd5, 4'd6);
        cyc(0, 0, 4'd0, 16'd0, 1, 4'd5, 4'd6);
        chk("dup_haz1", hazard1, 1);
        chk("dup_fwd1", fwd_data1, 16'h1234);
        chk("dup_haz2", hazard2, 0);
        chk("dup_fwd2", fwd_data2, 16'h0000);
        idle(4);

        // Writes to register zero retire silently.
        cyc(0, 1, 4'd0, 16'hABCD, 0, 4'd0, 4'd0);
        cyc(0, 0, 4'd0, 16'd0, 0, 4'd0, 4'd0);
        chk("r0_pending", pending, 1);
        cyc(0, 0, 4'd0, 16'd0, 0, 4'd0, 4'd0);
        chk("r0_no_we", RegWrite, 0);
        chk("r0_drained", pending, 0);

        // Reset mid-operation drops queued writes.
        for (int i = 0; i < 3; i++) cyc(0, 1, 4'(i + 8), 16'(16'hC000 + i), 1, 4'd8, 4'd9);
        cyc(1, 0, 4'd0, 16'd0, 1, 4'd8, 4'd9);
        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, 4'd0, 16'd0, 0, 4'd8, 4'd9);
            chk("rst_flush_we", RegWrite, 0);
        end
        chk("rst_flush_pending", pending, 0);

        // Random traffic.
        for (int n = 0; n < 500; n++) begin
            cyc(($urandom_range(0, 149) == 0), ($urandom_range(0, 3) != 0),
                4'($urandom_range(0, 7)), 16'($urandom),
                ($urandom_range(0, 9) < 4),
                4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)));
        end
        idle(6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
